// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control front end.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'd0,
        SW_RUN   = 2'd1,
        SW_PAUSE = 2'd2
    } sw_state_t;

    localparam int CLK_HZ        = 50_000_000;
    localparam int TICK_HZ       = 100;
    localparam int DEF_TICK_DIV  = CLK_HZ / TICK_HZ;
    localparam int DEF_DB_CYCLES = 1_000_000;

    localparam int NUM_KEYS  = 2;
    localparam int KEY_CLEAR = 0;
    localparam int KEY_START = 1;

    // Start/stop toggles between RUN and PAUSE; from IDLE it starts.
    function automatic sw_state_t start_next(input sw_state_t s);
        sw_state_t n;
        case (s)
            SW_IDLE:  n = SW_RUN;
            SW_RUN:   n = SW_PAUSE;
            SW_PAUSE: n = SW_RUN;
            default:  n = SW_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One raw active-low button: 2-flop synchroniser, stability counter and a
// single-cycle press pulse on the debounced 1->0 transition.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_next;
    logic             press_reg;
    logic             press_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // The flip happens on the DB_CYCLES-th consecutive mismatching cycle,
    // which is also where the press pulse is produced.
    always_comb begin
        level_next = level_reg;
        cnt_next   = '0;
        press_next = 1'b0;
        if (sync2_reg != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next = sync2_reg;
                press_next = level_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            cnt_reg   <= '0;
            press_reg <= 1'b0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            level_reg <= level_next;
            cnt_reg   <= cnt_next;
            press_reg <= press_next;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/idle control for the BCD stopwatch counter: owns the 10 ms
// timebase and issues registered tick and clear pulses.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] key_n,
    output logic       tick,
    output logic       clear,
    output logic       running
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [NUM_KEYS-1:0] press;
    logic                clear_press;
    logic                start_press;

    sw_state_t           state_reg;
    sw_state_t           state_next;
    logic [PW-1:0]       presc_reg;
    logic [PW-1:0]       presc_next;
    logic                tick_reg;
    logic                tick_next;
    logic                clear_reg;
    logic                clear_next;
    logic                running_reg;
    logic                running_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DB_CYCLES (DB_CYCLES)
            ) u_db (
                .CLOCK_50 (CLOCK_50),
                .reset    (reset),
                .key_n    (key_n[gi]),
                .press    (press[gi])
            );
        end
    endgenerate

    assign clear_press = press[KEY_CLEAR];
    assign start_press = press[KEY_START];

    // The prescaler step and tick depend only on the current state, so a
    // start press on the wrap cycle still delivers that tick before pausing.
    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        tick_next  = 1'b0;
        clear_next = 1'b0;

        if (state_reg == SW_RUN) begin
            tick_next  = (presc_reg == PRESC_LAST);
            presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + 1'b1;
        end else if (state_reg == SW_IDLE) begin
            presc_next = '0;
        end

        // Clear outranks start and suppresses any tick due on the same edge.
        if (clear_press) begin
            state_next = SW_IDLE;
            presc_next = '0;
            tick_next  = 1'b0;
            clear_next = 1'b1;
        end else if (start_press) begin
            state_next = start_next(state_reg);
        end

        running_next = (state_next == SW_RUN);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg   <= SW_IDLE;
            presc_reg   <= '0;
            tick_reg    <= 1'b0;
            clear_reg   <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            presc_reg   <= presc_next;
            tick_reg    <= tick_next;
            clear_reg   <= clear_next;
            running_reg <= running_next;
        end
    end

    assign tick    = tick_reg;
    assign clear   = clear_reg;
    assign running = running_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Segment table plus hand sequences; every cycle's expected tick/clear/running
// is queued when the stimulus is applied and compared on the falling edge.
module tb_stopwatch_ctrl;

    localparam int TD = 10;
    localparam int DB = 4;
    localparam int NSEG = 13;
    localparam int NBOUNCE = 50;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic [1:0] key_n    = 2'b11;
    logic       tick;
    logic       clear;
    logic       running;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int    cyc;
        logic  tick;
        logic  clear;
        logic  running;
        string name;
    } exp_t;

    // Expectations are relative to the cycle the key level is applied.
    typedef struct {
        string      name;
        logic [1:0] key_n;
        int         len;
        bit         run_before;
        bit         run_after;
        int         eff;
        int         tick_first;
        int         tick_last;
        int         clear_at;
    } seg_t;

    exp_t sb[$];
    seg_t tbl[NSEG];
    int   lo_len[NBOUNCE];
    int   hi_len[NBOUNCE];

    stopwatch_ctrl #(
        .TICK_DIV  (TD),
        .DB_CYCLES (DB)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n    (key_n),
        .tick     (tick),
        .clear    (clear),
        .running  (running)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic push_span(input string nm, input int s, input int len,
                             input bit rb, input bit ra, input int eff,
                             input int tf, input int tl, input int ca);
        for (int r = 1; r <= len; r++) begin
            exp_t e;
            e.cyc     = s + r;
            e.running = (eff > 0 && r >= eff) ? ra : rb;
            e.tick    = (tf > 0 && r >= tf && r <= tl && ((r - tf) % TD) == 0);
            e.clear   = (ca > 0 && r == ca);
            e.name    = nm;
            sb.push_back(e);
        end
    endtask

    task automatic apply_seg(input seg_t g);
        int s;
        s = cyc;
        key_n = g.key_n;
        push_span(g.name, s, g.len, g.run_before, g.run_after, g.eff,
                  g.tick_first, g.tick_last, g.clear_at);
        repeat (g.len) step();
    endtask

    task automatic check_now(input string nm, input logic [2:0] want);
        n_tests++;
        if ({tick, clear, running} !== want) begin
            n_fail++;
            $display("FAIL %s: tick/clear/running=%b required %b", nm, {tick, clear, running}, want);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge CLOCK_50);
            n_tests++;
            if (tick === 1'b1 && clear === 1'b1) begin
                n_fail++;
                $display("FAIL tick_clear_overlap: cycle %0d tick=1 clear=1", cyc);
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", sb[0].name, sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_tests++;
                if ({tick, clear, running} !== {e.tick, e.clear, e.running}) begin
                    n_fail++;
                    $display("FAIL %s: cycle %0d tick/clear/running=%b%b%b required %b%b%b",
                             e.name, cyc, tick, clear, running, e.tick, e.clear, e.running);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int total;
        //               name           key    len rb    ra    eff tf  tl  clr
        tbl[0]  = '{"idle_hold",   2'b11,  5, 1'b0, 1'b0, 0,  0,  0,  0};
        tbl[1]  = '{"start",       2'b01, 20, 1'b0, 1'b1, 7, 17, 20,  0};
        tbl[2]  = '{"start_rel",   2'b11, 37, 1'b1, 1'b1, 0,  7, 37,  0};
        tbl[3]  = '{"pause_at6",   2'b01, 20, 1'b1, 1'b0, 7,  0,  0,  0};
        tbl[4]  = '{"paused",      2'b11, 90, 1'b0, 1'b0, 0,  0,  0,  0};
        tbl[5]  = '{"resume",      2'b01, 20, 1'b0, 1'b1, 7, 10, 20,  0};
        tbl[6]  = '{"resume_rel",  2'b11, 15, 1'b1, 1'b1, 0, 10, 15,  0};
        tbl[7]  = '{"both_clear",  2'b00, 20, 1'b1, 1'b0, 7,  5,  6,  7};
        tbl[8]  = '{"both_rel",    2'b11, 20, 1'b0, 1'b0, 0,  0,  0,  0};
        tbl[9]  = '{"restart",     2'b01, 20, 1'b0, 1'b1, 7, 17, 20,  0};
        tbl[10] = '{"restart_rel", 2'b11, 12, 1'b1, 1'b1, 0,  7, 12,  0};
        tbl[11] = '{"post_reset",  2'b01, 20, 1'b0, 1'b1, 7, 17, 20,  0};
        tbl[12] = '{"post_rel",    2'b11, 10, 1'b1, 1'b1, 0,  7, 10,  0};

        fork
            monitor_loop();
        join_none

        #5 reset = 1'b1;
        #1 check_now("reset_async", 3'b000);
        repeat (3) step();
        reset = 1'b0;

        for (int i = 0; i <= 10; i++) apply_seg(tbl[i]);

        // Reset lands in the cycle just before a tick is due.
        push_span("pre_reset", cyc, 3, 1'b1, 1'b1, 0, 0, 0, 0);
        repeat (3) step();
        push_span("in_reset", cyc, 17, 1'b0, 1'b0, 0, 0, 0, 0);
        step();
        #4 reset = 1'b1;
        #1 check_now("reset_midrun", 3'b000);
        repeat (3) step();
        reset = 1'b0;
        repeat (13) step();

        for (int i = 11; i < NSEG; i++) apply_seg(tbl[i]);

        // Short low glitches on start/stop while running must not register.
        total = 0;
        for (int i = 0; i < NBOUNCE; i++) begin
            lo_len[i] = int'($urandom_range(1, 3));
            hi_len[i] = int'($urandom_range(1, 3));
            total += lo_len[i] + hi_len[i];
        end
        push_span("bounce", cyc, total + 10, 1'b1, 1'b1, 0, 7, total + 10, 0);
        for (int i = 0; i < NBOUNCE; i++) begin
            key_n = 2'b01;
            repeat (lo_len[i]) step();
            key_n = 2'b11;
            repeat (hi_len[i]) step();
        end
        repeat (10) step();

        step();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
